// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Front-end controller for the 4-bit adder / display mux. The user keys
//   opA, then opB, on four switches and advances with a single push button.
//   In SHOW the button then steps the display select through
//   sum -> carry -> opB -> opA. The carry of the displayed result is
//   latched into ovf for the status LED.
//
// Ports
//   clk      system clock, everything on the rising edge
//   rst      synchronous active-high reset
//   sw[3:0]  operand switches (async, quasi-static, deliberately unsynchronised)
//   btn      raw bouncy push button (async, active-high)
//   sum[4:0] adder result {carry, sum} computed outside from opA/opB
//   opA/opB  operands to the adder and mux
//   dsp_sel  display select: 00 sum, 01 carry, 10 opB, 11 opA
//   state    FSM state code for the LEDs
//   ovf      registered carry flag
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic [4:0] sum,
    output logic [3:0] opA,
    output logic [3:0] opB,
    output logic [1:0] dsp_sel,
    output logic [1:0] state,
    output logic       ovf
);

    localparam logic [1:0] LOAD_A = 2'b00;
    localparam logic [1:0] LOAD_B = 2'b01;
    localparam logic [1:0] SHOW   = 2'b10;

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button path: 2-flop synchroniser, counting debouncer, rising-edge
    // press pulse. The pulse is registered, so the FSM sees it two edges
    // after the stable level rises.
    // ------------------------------------------------------------------
    logic          sync1, sync2;
    logic          stable, stable_q;
    logic          press;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // synchronised level disagreed for DEBOUNCE_CYCLES edges in a row
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM. show_first marks the first edge spent in SHOW, which
    // is when the (by then frozen) operands' carry is captured.
    // ------------------------------------------------------------------
    logic show_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            opA        <= 4'd0;
            opB        <= 4'd0;
            dsp_sel    <= 2'b11;
            ovf        <= 1'b0;
            show_first <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    opA     <= sw;
                    dsp_sel <= 2'b11;
                    if (press) begin
                        state   <= LOAD_B;
                        dsp_sel <= 2'b10;
                    end
                end
                LOAD_B: begin
                    opB     <= sw;
                    dsp_sel <= 2'b10;
                    if (press) begin
                        state      <= SHOW;
                        dsp_sel    <= 2'b00;
                        show_first <= 1'b1;
                    end
                end
                SHOW: begin
                    show_first <= 1'b0;
                    if (show_first) begin
                        ovf <= sum[4];
                    end
                    if (press) begin
                        if (dsp_sel == 2'b11) begin
                            state   <= LOAD_A;
                            dsp_sel <= 2'b11;
                            ovf     <= 1'b0;
                            opB     <= 4'd0;
                        end else begin
                            dsp_sel <= dsp_sel + 2'b01;
                        end
                    end
                end
                default: begin
                    // illegal code 11: fall back to the reset picture
                    state      <= LOAD_A;
                    opA        <= 4'd0;
                    opB        <= 4'd0;
                    dsp_sel    <= 2'b11;
                    ovf        <= 1'b0;
                    show_first <= 1'b0;
                end
            endcase
        end
    end

endmodule
